// File: rtl/fetch_pkg.sv
// Shared definitions for the IF-stage fetch sequencer: FSM state encoding,
// performance counter width and default cycle counts.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int unsigned PERF_W           = 16;
  localparam int unsigned BOOT_CYCLES_DEF  = 2;
  localparam int unsigned DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the fetch sequencer performance counters.
// Holds at all-ones instead of wrapping.
module sat_counter
  import fetch_pkg::*;
#(
  parameter int unsigned W = PERF_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // Next count: increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared by asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage sequencing controller: arbitrates EX branch redirects, ID jump
// redirects and load-use stalls, and runs the post-reset boot hold and the
// EBREAK drain/halt sequence. All control outputs are combinational from the
// registered state and the current requests.
// Optional feature: define FETCH_PERF_EN to add the stall_cnt/flush_cnt ports.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned PC_SIZE      = 32,
  parameter int unsigned BOOT_CYCLES  = BOOT_CYCLES_DEF,
  parameter int unsigned DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               stall_req,
  input  logic               br_taken,
  input  logic [PC_SIZE-1:0] br_target,
  input  logic               jmp_req,
  input  logic [PC_SIZE-1:0] jmp_target,
  input  logic               halt_req,
  output logic               pc_sel,
  output logic [PC_SIZE-1:0] pc_target,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_flush,
`ifdef FETCH_PERF_EN
  output logic               halted,
  output logic [PERF_W-1:0]  stall_cnt,
  output logic [PERF_W-1:0]  flush_cnt
`else
  output logic               halted
`endif
);

  localparam int unsigned CNT_MAX = (BOOT_CYCLES > DRAIN_CYCLES) ? BOOT_CYCLES : DRAIN_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state, cycle counter and control outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_sel     = 1'b0;
    pc_target  = '0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    halted     = 1'b0;
    unique case (state_q)
      BOOT: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RUN: begin
        if (br_taken) begin
          pc_sel     = 1'b1;
          pc_target  = br_target;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (stall_req) begin
          idex_flush = 1'b1;
        end else if (halt_req) begin
          ifid_flush = 1'b1;
          state_d    = DRAIN;
          cnt_d      = CNT_W'(DRAIN_CYCLES);
        end else if (jmp_req) begin
          pc_sel     = 1'b1;
          pc_target  = jmp_target;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ifid_en = 1'b1;
        end
      end
      DRAIN: begin
        ifid_flush = 1'b1;
        if (br_taken) begin
          // Halt came from a wrong-path EBREAK: redirect and resume.
          pc_sel     = 1'b1;
          pc_target  = br_target;
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          idex_flush = 1'b1;
          state_d    = RUN;
          cnt_d      = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = HALT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HALT: begin
        halted     = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: begin
        state_d = BOOT;
        cnt_d   = CNT_W'(BOOT_CYCLES);
      end
    endcase
  end

  // State and cycle counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      cnt_q   <= CNT_W'(BOOT_CYCLES);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = (state_q == RUN) && !br_taken && stall_req;
  assign flush_inc = ifid_flush && ((state_q == RUN) || (state_q == DRAIN));

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clock),
    .rst_n (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_flush_cnt (
    .clk   (clock),
    .rst_n (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule
